// File: rtl/add_pkg.sv
// ----------------------------------------------------------------------------
// add_pkg
//
// Definitions shared by the registered signed adder and its downstream
// consumers (sum_avg and later decimators).
//
//   DIM_DEFAULT : datapath width used by both the adder and sum_avg, so that
//                 the adder's `sum` and the decimator's `in_data` always agree.
//   sa_state_t  : state encoding of the sum_avg control FSM.
//                 There are two states:
//                   S_IDLE - inputs are ignored
//                   S_RUN  - qualified samples are accumulated
// ----------------------------------------------------------------------------
package add_pkg;

    localparam int DIM_DEFAULT = 14;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } sa_state_t;

endpackage : add_pkg

// File: rtl/sum_avg_round.sv
// ----------------------------------------------------------------------------
// sum_avg_round
//
// Purely combinational block-mean rounding. It turns the signed sum of a
// 2^LOG2N sample block into the rounded signed mean.
//
// Rounding is round-half-toward-+inf. Half an output LSB is added, and the
// result is then arithmetically shifted right by LOG2N bits. The intermediate
// value is one bit wider than `total`, so adding the bias can never wrap. The
// mean of DIM-bit samples always fits in DIM bits, so the final truncation
// discards only sign-extension bits.
//
// Parameters:
//   DIM   - sample and result width
//   LOG2N - log2 of the block length (1..8)
//
// Ports:
//   total - signed block sum,  DIM+LOG2N bits
//   mean  - signed rounded mean, DIM bits
// ----------------------------------------------------------------------------
module sum_avg_round
    import add_pkg::*;
#(
    parameter int DIM   = DIM_DEFAULT,
    parameter int LOG2N = 2
) (
    input  logic signed [DIM+LOG2N-1:0] total,
    output logic signed [DIM-1:0]       mean
);

    localparam int TW = DIM + LOG2N;   // width of the incoming sum
    localparam int RW = TW + 1;        // headroom for the rounding bias

    // Half of one output LSB, expressed in input LSBs.
    localparam logic signed [RW-1:0] HALF = RW'(1) << (LOG2N - 1);

    logic signed [RW-1:0] total_ext;
    logic signed [RW-1:0] biased;

    assign total_ext = {total[TW-1], total};
    assign biased    = total_ext + HALF;

    // The arithmetic shift floors toward -inf. With the half-LSB bias
    // already added, this gives round-half-up on the true mean.
    assign mean = DIM'(biased >>> LOG2N);

endmodule : sum_avg_round

// File: rtl/sum_avg.sv
// ----------------------------------------------------------------------------
// sum_avg
//
// Block-averaging decimator. It sits directly downstream of the registered
// signed adder. It accumulates 2^LOG2N qualified samples per block and emits
// one rounded signed mean per block on a valid/ready output.
//
// If a block completes while the previous result is still unconsumed, the new
// result is dropped and the sticky `ovr` flag is set.
//
// Parameters:
//   DIM   - sample and result width (matches the adder's sum width)
//   LOG2N - log2 of block length N (1..8)
//
// Ports:
//   clk       in   1    sole clock, posedge
//   rst       in   1    synchronous active-high reset
//   start     in   1    pulse that begins or restarts block alignment
//   in_data   in   DIM  signed sample
//   in_valid  in   1    qualifies in_data (only looked at in RUN)
//   out_data  out  DIM  signed block mean
//   out_valid out  1    out_data holds an unconsumed result
//   out_ready in   1    consumer accepts when out_valid && out_ready
//   ovr       out  1    sticky overrun flag, cleared only by rst
//   busy      out  1    high while in RUN
// ----------------------------------------------------------------------------
module sum_avg
    import add_pkg::*;
#(
    parameter int DIM   = DIM_DEFAULT,
    parameter int LOG2N = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic signed [DIM-1:0] in_data,
    input  logic                  in_valid,
    output logic signed [DIM-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ovr,
    output logic                  busy
);

    localparam int AW = DIM + LOG2N;   // accumulator width; holds N samples

    // The counter is exactly LOG2N bits wide, so "all ones" is N-1.
    localparam logic [LOG2N-1:0] CNT_LAST = '1;
    localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    sa_state_t              state_reg,     state_next;
    logic signed [AW-1:0]   acc_reg,       acc_next;
    logic [LOG2N-1:0]       cnt_reg,       cnt_next;
    logic signed [DIM-1:0]  out_data_reg,  out_data_next;
    logic                   out_valid_reg, out_valid_next;
    logic                   ovr_reg,       ovr_next;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic signed [AW-1:0]   in_ext;
    logic signed [AW-1:0]   total;
    logic signed [DIM-1:0]  mean;
    logic                   sample_qual;
    logic                   block_done;
    logic                   accept;

    assign in_ext = {{LOG2N{in_data[DIM-1]}}, in_data};

    // Running sum including the current sample. It is used both for the
    // ordinary accumulate step and as the completed block total.
    assign total = acc_reg + in_ext;

    // The sample presented alongside `start` is never counted. A `start`
    // that coincides with the last sample of a block therefore also
    // suppresses that block's completion.
    assign sample_qual = (state_reg == S_RUN) && !start && in_valid;
    assign block_done  = sample_qual && (cnt_reg == CNT_LAST);
    assign accept      = out_valid_reg && out_ready;

    sum_avg_round #(
        .DIM   (DIM),
        .LOG2N (LOG2N)
    ) u_round (
        .total (total),
        .mean  (mean)
    );

    // ------------------------------------------------------------------
    // Next-state logic: FSM, accumulator/counter, output register
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        ovr_next       = ovr_reg;

        // Control: start (re)aligns from either state. Only rst returns
        // the FSM to IDLE.
        if (start) begin
            state_next = S_RUN;
            acc_next   = '0;
            cnt_next   = '0;
        end else if (sample_qual) begin
            if (block_done) begin
                acc_next = '0;
                cnt_next = '0;
            end else begin
                acc_next = total;
                cnt_next = cnt_reg + CNT_ONE;
            end
        end

        // Output register. A completion may load in the same cycle that the
        // old result is accepted, so back-to-back results show no gap in
        // out_valid. A completion against a stalled result is dropped and
        // recorded in ovr; out_data stays stable for the consumer.
        if (block_done) begin
            if (!out_valid_reg || out_ready) begin
                out_data_next  = mean;
                out_valid_next = 1'b1;
            end else begin
                ovr_next = 1'b1;
            end
        end else if (accept) begin
            out_valid_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            ovr_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            ovr_reg       <= ovr_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign ovr       = ovr_reg;
    assign busy      = (state_reg == S_RUN);

endmodule : sum_avg

// File: tb/tb_sum_avg.sv
// ----------------------------------------------------------------------------
// tb_sum_avg
//
// Directed bench for sum_avg with DIM=14 and LOG2N=2 (N=4).
//
// The stimulus process pushes each hand-computed block mean into exp_q when it
// issues the block's final sample. A separate monitor pops one entry per
// accepted output (out_valid && out_ready) and compares it. Flag and hold
// behaviour is checked directly from the stimulus process.
// ----------------------------------------------------------------------------
module tb_sum_avg;

    localparam int DIM   = 14;
    localparam int LOG2N = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic signed [DIM-1:0] in_data;
    logic                  in_valid;
    logic signed [DIM-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  ovr;
    logic                  busy;

    int exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sum_avg #(
        .DIM   (DIM),
        .LOG2N (LOG2N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovr       (ovr),
        .busy      (busy)
    );

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic smp(input int v);
        in_valid = 1'b1;
        in_data  = DIM'(v);
        cyc();
        in_valid = 1'b0;
    endtask

    // Pulse start with a qualified junk sample, which must not be counted.
    task automatic pulse_start(input int junk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = DIM'(junk);
        cyc();
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor: it samples on the falling edge, half a cycle from
    // the edge that performs the transfer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %0d, required none", out_data);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("result", int'(out_data), e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);

        chk("rst_out_data",  int'(out_data), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_ovr",       int'(ovr), 0);
        chk("rst_busy",      int'(busy), 0);

        // Positive rounding: (1+2+3+4+2)>>2 = 3
        pulse_start(50);
        chk("busy_after_start", int'(busy), 1);
        smp(1); smp(2); smp(3);
        exp_q.push_back(3);
        smp(4);
        chk("pos_valid", int'(out_valid), 1);
        idle(1);
        chk("pos_valid_one_cycle", int'(out_valid), 0);
        chk("pos_ovr", int'(ovr), 0);

        // Negative rounding: (-10+2)>>>2 = -2 ; (-5+2)>>>2 = -1
        smp(-1); smp(-2); smp(-3);
        exp_q.push_back(-2);
        smp(-4);
        smp(-1); smp(-1); smp(-1);
        exp_q.push_back(-1);
        smp(-2);

        // Extremes
        smp(8191); smp(8191); smp(8191);
        exp_q.push_back(8191);
        smp(8191);
        smp(-8192); smp(-8192); smp(-8192);
        exp_q.push_back(-8192);
        smp(-8192);
        smp(8191); smp(8191); smp(-8192);
        exp_q.push_back(0);
        smp(-8192);
        idle(2);

        // Restart discards a partial block
        smp(100); smp(100);
        pulse_start(999);
        smp(4); smp(4); smp(4);
        exp_q.push_back(4);
        smp(4);
        idle(2);

        // start coincident with the 4th sample: no result
        smp(7); smp(7); smp(7);
        pulse_start(7);
        idle(2);
        chk("start_coincident_no_valid", int'(out_valid), 0);

        // in_valid gaps: (3+5+7+9+2)>>2 = 6
        smp(3); idle(1);
        smp(5); idle(2);
        smp(7);
        exp_q.push_back(6);
        smp(9);
        idle(2);
        chk("no_ovr_yet", int'(ovr), 0);

        // Backpressure across two blocks: hold 1, drop 5, set ovr
        out_ready = 1'b0;
        smp(1); smp(1); smp(1);
        exp_q.push_back(1);
        smp(1);
        smp(5); smp(5); smp(5); smp(5);
        chk("bp_hold_data",  int'(out_data), 1);
        chk("bp_hold_valid", int'(out_valid), 1);
        chk("bp_ovr",        int'(ovr), 1);
        out_ready = 1'b1;
        cyc();
        chk("bp_drained_valid", int'(out_valid), 0);

        // Completion in the same cycle as acceptance: no gap
        out_ready = 1'b0;
        smp(2); smp(2); smp(2);
        exp_q.push_back(2);
        smp(2);
        idle(2);
        chk("stall_hold_data", int'(out_data), 2);
        smp(6); smp(6); smp(6);
        exp_q.push_back(6);
        out_ready = 1'b1;
        smp(6);
        chk("same_cycle_valid", int'(out_valid), 1);
        chk("same_cycle_data",  int'(out_data), 6);
        idle(2);
        chk("same_cycle_drained", int'(out_valid), 0);

        // Reset with a pending result, ovr set and a partial block
        out_ready = 1'b0;
        smp(1); smp(1); smp(1); smp(1);
        smp(5); smp(5); smp(5); smp(5);
        smp(9); smp(9); smp(9);
        chk("pre_rst_ovr",   int'(ovr), 1);
        chk("pre_rst_valid", int'(out_valid), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("post_rst_out_data",  int'(out_data), 0);
        chk("post_rst_out_valid", int'(out_valid), 0);
        chk("post_rst_ovr",       int'(ovr), 0);
        chk("post_rst_busy",      int'(busy), 0);

        // Samples without start after reset are ignored
        out_ready = 1'b1;
        smp(4); smp(4); smp(4); smp(4);
        idle(3);
        chk("idle_no_valid", int'(out_valid), 0);
        chk("idle_busy",     int'(busy), 0);

        chk("sb_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sum_avg
